rom_word_arbiter: RTL and testbench
===================================

ROM_WORD_ARBITER -- requirements
Module: rom_word_arbiter

Interface
REQ-001 The block SHALL have parameter awidth, default 14, giving the ROM byte-address width; word address width is awidth-1.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  port 0 word request, level, held until ack0.
REQ-005 addr0  input  awidth-1  port 0 word address.
REQ-006 ack0  output  1  one-cycle pulse: rdata holds port 0 word.
REQ-007 req1  input  1  port 1 word request, level, held until ack1.
REQ-008 addr1  input  awidth-1  port 1 word address.
REQ-009 ack1  output  1  one-cycle pulse: rdata holds port 1 word.
REQ-010 rdata  output  16  fetched word, big-endian: even byte in [15:8], odd byte in [7:0].
REQ-011 rom_addr  output  awidth  byte address to the external 8-bit ROM, which registers its address and returns q one cycle later.
REQ-012 rom_q  input  8  ROM read data.
REQ-013 busy  output  1  high in every non-IDLE state.
REQ-014 gnt  output  1  port being or last served (0/1).

Function
REQ-015 The FSM SHALL have states IDLE, A_HI, A_LO, C_LO.
REQ-016 IDLE: if an eligible request exists, grant it, latch its address into wa, go to A_HI; else stay.
REQ-017 Arbitration SHALL be round-robin: with both eligible, grant the port not equal to gnt; with one eligible, grant it.
REQ-018 In the cycle ackN is high, portN's request SHALL be ineligible (masked), so a held req is not re-served before the requester drops it.
REQ-019 A_HI: rom_addr = {wa,0}; go to A_LO.
REQ-020 A_LO: rom_addr = {wa,1}; capture rom_q into hi register; go to C_LO.
REQ-021 C_LO: load rdata = {hi, rom_q}, set ack of granted port for the next cycle, go to IDLE.
REQ-022 In IDLE and C_LO, rom_addr SHALL hold its last value (no spurious change).
REQ-023 Latency: req sampled at edge k, ack high and rdata valid in the cycle following edge k+3 (4 cycles); back-to-back same port period 5 cycles; alternating ports period 4 cycles.
REQ-024 ack0 and ack1 SHALL be registered, never high together, and high for exactly one cycle per fetch.
REQ-025 rdata SHALL hold its value until the next C_LO completion.
REQ-026 Changes to addrN or deassertion of reqN after grant SHALL NOT affect the fetch in progress; the fetch completes and ack still pulses.
REQ-027 Requests arriving while busy SHALL wait; none is lost while req is held.
REQ-028 Word address all-ones SHALL fetch bytes 2^awidth-2 and 2^awidth-1 without wrap into address 0.

Reset
REQ-029 While reset is high: state IDLE, ack0=ack1=0, busy=0, gnt=1 (so port 0 wins first tie), rdata=0, rom_addr=0, hi=0, wa=0.
REQ-030 Reset asserted mid-fetch SHALL abort it with no ack; first request after deassertion is served normally.

Structure
REQ-031 State encodings and the default awidth SHALL be constants in the shared package; no other typedefs.
REQ-032 The block SHALL be a single module with no sub-modules; the ROM (existing single-port sprom) is instantiated by the parent, and by the bench alongside the DUT.

Verification
REQ-033 Single fetch: ROM byte2=0x12, byte3=0x34; req0 with addr0=1 -> ack0 one cycle, 4 cycles after req, rdata=0x1234, ack1 never high.
REQ-034 Tie: req0 and req1 rise together after reset, addr0=0, addr1=2 -> port 0 served first, then port 1; rdata words match ROM; acks 4 cycles apart.
REQ-035 Held req: req0 held high across 3 acks with addr0 stepping 0,1,2 -> acks every 5 cycles, rdata correct each time, no duplicate fetch.
REQ-036 Fairness: req0 and req1 both held for 10 fetches -> grants strictly alternate 0,1,0,1,...
REQ-037 Reset mid-fetch: assert reset in A_LO -> no ack, busy=0, rdata=0 immediately; next req1 addr1=all-ones -> rdata = {byte 2^awidth-2, byte 2^awidth-1}.
REQ-038 Address change after grant: addr0 changes 0->5 during A_HI -> rdata reflects word 0.

Source files
------------

// File: rtl/rom_word_arbiter_pkg.sv
// Shared constants for the two-port ROM word arbiter: FSM encoding and default ROM address width.
package rom_word_arbiter_pkg;
  localparam int AWIDTH_DEF = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    A_HI = 2'd1,
    A_LO = 2'd2,
    C_LO = 2'd3
  } state_t;
endpackage

// File: rtl/rom_word_arbiter_if.sv
// Two requester ports plus the shared word result bus of the ROM word arbiter.
interface rom_word_arbiter_if #(parameter int awidth = rom_word_arbiter_pkg::AWIDTH_DEF);
  logic              req0;
  logic [awidth-2:0] addr0;
  logic              ack0;
  logic              req1;
  logic [awidth-2:0] addr1;
  logic              ack1;
  logic [15:0]       rdata;
  logic              busy;
  logic              gnt;

  modport slave (
    input  req0, addr0, req1, addr1,
    output ack0, ack1, rdata, busy, gnt
  );

  modport master (
    output req0, addr0, req1, addr1,
    input  ack0, ack1, rdata, busy, gnt
  );
endinterface

// File: rtl/rom_word_arbiter.sv
// Round-robin arbiter fetching 16-bit big-endian words for two ports from a registered 8-bit ROM.
// Each fetch issues two byte reads back to back and pulses the granted port's ack once.
module rom_word_arbiter
  import rom_word_arbiter_pkg::*;
#(
  parameter int awidth = AWIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  rom_word_arbiter_if.slave bus,
  output logic [awidth-1:0] rom_addr,
  input  logic [7:0]        rom_q
);

  state_t            state, state_d;
  logic [awidth-2:0] wa;
  logic [7:0]        hi;
  logic [15:0]       rdata_q;
  logic              ack0_q, ack1_q, gnt_q;
  logic              el0, el1, sel, grant, fin;
  logic [awidth-2:0] sel_addr;

  // A port is masked during its own ack cycle so a still-held req is not re-served.
  always_comb begin
    el0      = bus.req0 & ~ack0_q;
    el1      = bus.req1 & ~ack1_q;
    sel      = (el0 & el1) ? ~gnt_q : el1;
    sel_addr = sel ? bus.addr1 : bus.addr0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    grant   = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: if (el0 | el1) begin
        state_d = A_HI;
        grant   = 1'b1;
      end
      A_HI: state_d = A_LO;
      A_LO: state_d = C_LO;
      C_LO: begin
        state_d = IDLE;
        fin     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // rom_addr is loaded one state ahead so the ROM samples the even byte at the end of A_HI
  // and the odd byte at the end of A_LO; it holds in IDLE and C_LO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wa       <= '0;
      hi       <= '0;
      rdata_q  <= '0;
      rom_addr <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      gnt_q    <= 1'b1;
    end else begin
      ack0_q <= fin & ~gnt_q;
      ack1_q <= fin &  gnt_q;
      if (grant) begin
        gnt_q    <= sel;
        wa       <= sel_addr;
        rom_addr <= {sel_addr, 1'b0};
      end
      if (state == A_HI) rom_addr <= {wa, 1'b1};
      if (state == A_LO) hi <= rom_q;
      if (fin)           rdata_q <= {hi, rom_q};
    end
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;
  assign bus.gnt   = gnt_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_rom_word_arbiter.sv
// Directed bench for rom_word_arbiter with a registered 8-bit ROM model beside the DUT.
module tb_rom_word_arbiter;
  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_q = 8'h00;
  logic [7:0]    mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;
  int nack0 = 0;
  int nack1 = 0;

  rom_word_arbiter_if #(.awidth(AW)) bus ();

  rom_word_arbiter #(.awidth(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_q    (rom_q)
  );

  always #5 clock = ~clock;

  // Single-port ROM: address registered, data one cycle later.
  always @(posedge clock) rom_q <= mem[rom_addr];

  always @(negedge clock) begin
    if (!reset) begin
      nack0 = nack0 + int'(bus.ack0);
      nack1 = nack1 + int'(bus.ack1);
      checks++;
      assert (!(bus.ack0 && bus.ack1)) else begin
        errors++;
        $error("FAIL ack_overlap obs=11 exp=not both");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until the named port acks or the bound expires; n is the tick count taken.
  task automatic wait_ack(input int port, input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(port == 1 ? bus.ack1 : bus.ack0) && n < maxc);
  endtask

  task automatic wait_any(input int maxc, output int p, output int n);
    n = 0;
    p = -1;
    do begin
      tick();
      n++;
    end while (!(bus.ack0 || bus.ack1) && n < maxc);
    if (bus.ack0) p = 0;
    else if (bus.ack1) p = 1;
  endtask

  initial begin
    int n, p, a0, a1, expp;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
    mem[0] = 8'hA0; mem[1] = 8'hA1;
    mem[2] = 8'h12; mem[3] = 8'h34;
    mem[4] = 8'h56; mem[5] = 8'h78;
    mem[10] = 8'hDE; mem[11] = 8'hAD;
    mem[(1<<AW)-2] = 8'hBE; mem[(1<<AW)-1] = 8'hEF;

    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd1);
    chk("rst_acks", 32'({bus.ack0, bus.ack1}), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_romaddr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    tick();

    // single fetch, word 1
    bus.req0 = 1'b1; bus.addr0 = 13'd1;
    tick();
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_gnt", 32'(bus.gnt), 32'd0);
    chk("single_romaddr_hi", 32'(rom_addr), 32'd2);
    wait_ack(0, 8, n);
    chk("single_lat", 32'(n + 1), 32'd4);
    chk("single_ack0", 32'(bus.ack0), 32'd1);
    chk("single_ack1", 32'(bus.ack1), 32'd0);
    chk("single_rdata", 32'(bus.rdata), 32'h1234);
    bus.req0 = 1'b0;
    tick();
    chk("single_ack_width", 32'(bus.ack0), 32'd0);
    chk("single_idle", 32'(bus.busy), 32'd0);
    chk("single_hold", 32'(bus.rdata), 32'h1234);
    chk("single_nack1", 32'(nack1), 32'd0);

    // tie after reset: port 0 first
    reset = 1'b1; tick(); reset = 1'b0; tick();
    bus.req0 = 1'b1; bus.addr0 = 13'd0; bus.req1 = 1'b1; bus.addr1 = 13'd2;
    wait_ack(0, 8, n);
    chk("tie_lat0", 32'(n), 32'd4);
    chk("tie_first", 32'({bus.ack0, bus.ack1}), 32'b10);
    chk("tie_rdata0", 32'(bus.rdata), 32'hA0A1);
    bus.req0 = 1'b0;
    wait_ack(1, 8, n);
    chk("tie_gap", 32'(n), 32'd4);
    chk("tie_ack1", 32'(bus.ack1), 32'd1);
    chk("tie_rdata1", 32'(bus.rdata), 32'h5678);
    bus.req1 = 1'b0;
    tick(); tick();

    // held req0 stepping addresses
    a0 = nack0;
    bus.req0 = 1'b1; bus.addr0 = 13'd0;
    wait_ack(0, 8, n);
    chk("held_lat", 32'(n), 32'd4);
    chk("held_rd0", 32'(bus.rdata), 32'hA0A1);
    bus.addr0 = 13'd1;
    wait_ack(0, 8, n);
    chk("held_per1", 32'(n), 32'd5);
    chk("held_rd1", 32'(bus.rdata), 32'h1234);
    bus.addr0 = 13'd2;
    wait_ack(0, 8, n);
    chk("held_per2", 32'(n), 32'd5);
    chk("held_rd2", 32'(bus.rdata), 32'h5678);
    bus.req0 = 1'b0;
    tick(); tick(); tick();
    chk("held_count", 32'(nack0 - a0), 32'd3);

    // fairness: port 0 was last served, so port 1 leads
    a0 = nack0; a1 = nack1;
    bus.req0 = 1'b1; bus.addr0 = 13'd1; bus.req1 = 1'b1; bus.addr1 = 13'd5;
    expp = 1;
    for (int i = 0; i < 10; i++) begin
      wait_any(8, p, n);
      chk("fair_port", 32'(p), 32'(expp));
      chk("fair_per", 32'(n), 32'd4);
      chk("fair_rdata", 32'(bus.rdata), (expp == 1) ? 32'hDEAD : 32'h1234);
      expp = 1 - expp;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(); tick();
    chk("fair_n0", 32'(nack0 - a0), 32'd5);
    chk("fair_n1", 32'(nack1 - a1), 32'd5);

    // reset in A_LO aborts the fetch
    a0 = nack0;
    bus.req0 = 1'b1; bus.addr0 = 13'd2;
    tick(); tick();
    chk("abort_romaddr_lo", 32'(rom_addr), 32'd5);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rdata", 32'(bus.rdata), 32'd0);
    chk("abort_ack0", 32'(bus.ack0), 32'd0);
    chk("abort_gnt", 32'(bus.gnt), 32'd1);
    chk("abort_romaddr", 32'(rom_addr), 32'd0);
    tick();
    reset = 1'b0; bus.req0 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("abort_noack", 32'(nack0 - a0), 32'd0);

    // all-ones word address reads the top two bytes
    bus.req1 = 1'b1; bus.addr1 = 13'h1FFF;
    tick();
    chk("top_romaddr_hi", 32'(rom_addr), 32'h3FFE);
    tick();
    chk("top_romaddr_lo", 32'(rom_addr), 32'h3FFF);
    wait_ack(1, 6, n);
    chk("top_lat", 32'(n + 2), 32'd4);
    chk("top_rdata", 32'(bus.rdata), 32'hBEEF);
    bus.req1 = 1'b0;
    tick();

    // address change after grant does not disturb the fetch
    bus.req0 = 1'b1; bus.addr0 = 13'd0;
    tick();
    bus.addr0 = 13'd5;
    bus.req0 = 1'b0;
    wait_ack(0, 6, n);
    chk("late_lat", 32'(n + 1), 32'd4);
    chk("late_ack0", 32'(bus.ack0), 32'd1);
    chk("late_rdata", 32'(bus.rdata), 32'hA0A1);
    tick(); tick(); tick();
    chk("late_hold", 32'(bus.rdata), 32'hA0A1);
    chk("late_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
